// File: rtl/apot4_requant.sv
// APoT4 output requantizer: shift, optional ReLU, nearest-level APoT4 code.
// Two-stage valid/ready pipeline with a saturating count of clipped results.
module apot4_requant #(
  parameter int ACC_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_WIDTH-1:0]   in_acc,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic                   in_relu,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_code,
  output logic [CNT_WIDTH-1:0]   sat_count
);

  localparam int MW = ACC_WIDTH + 1;

  logic          advance;
  logic [MW-1:0] ext;
  logic [MW-1:0] abs_val;
  logic [MW-1:0] mag_sh;

  logic          s1_valid;
  logic          s1_neg;
  logic          s1_relu;
  logic [MW-1:0] s1_mag;

  logic          big;
  logic          nz;
  logic          sat;
  logic [2:0]    term;
  logic [3:0]    code_nxt;
  logic          sat_nxt;
  logic          s2_sat;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // One extra bit keeps |most-negative| exact
  assign ext     = {in_acc[ACC_WIDTH-1], in_acc};
  assign abs_val = in_acc[ACC_WIDTH-1] ? (~ext + 1'b1) : ext;
  assign mag_sh  = (32'(in_shift) >= MW) ? '0 : (abs_val >> in_shift);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_neg   <= 1'b0;
      s1_relu  <= 1'b0;
      s1_mag   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_neg   <= in_acc[ACC_WIDTH-1];
      s1_relu  <= in_relu;
      s1_mag   <= mag_sh;
    end
  end

  assign big = s1_mag > MW'(10);
  assign nz  = s1_mag != '0;

  // Nearest level, ties resolved toward the smaller level
  always_comb begin
    term = 3'b000;
    sat  = 1'b0;
    if (big) begin
      term = 3'b011;
      sat  = 1'b1;
    end else begin
      case (s1_mag[3:0])
        4'd0:        term = 3'b000;
        4'd1:        term = 3'b110;
        4'd2:        term = 3'b001;
        4'd3:        term = 3'b111;
        4'd4, 4'd5:  term = 3'b100;
        4'd6, 4'd7:  term = 3'b101;
        4'd8, 4'd9:  term = 3'b010;
        4'd10:       term = 3'b011;
        default:     term = 3'b000;
      endcase
    end
  end

  always_comb begin
    code_nxt = {s1_neg && nz, term};
    sat_nxt  = sat;
    if (s1_relu && s1_neg) begin
      code_nxt = 4'b0000;
      sat_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_code  <= 4'b0000;
      s2_sat    <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_code  <= code_nxt;
      s2_sat    <= sat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && s2_sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_apot4_requant.sv
// Randomized and directed bench for apot4_requant against a level-table model.
// Uses a 4-bit counter so counter saturation is reachable quickly.
module tb_apot4_requant;

  localparam int AW = 16;
  localparam int SW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_acc = '0;
  logic [SW-1:0] in_shift = '0;
  logic          in_relu = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_code;
  logic [CW-1:0] sat_count;

  int vectors = 0;
  int errors = 0;
  logic [3:0] q_code[$];
  bit         q_sat[$];
  int         exp_cnt = 0;

  apot4_requant #(
    .ACC_WIDTH(AW),
    .SHIFT_WIDTH(SW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_acc(in_acc),
    .in_shift(in_shift),
    .in_relu(in_relu),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code(out_code),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  // Reference: pick the nearest representable level by distance
  function automatic void ref_model(input int acc, input int sh,
                                    input bit relu,
                                    output logic [3:0] code,
                                    output bit sat);
    int levels[8];
    logic [2:0] enc[8];
    longint m;
    longint d_i;
    longint d_b;
    int best;
    levels = '{0, 1, 2, 3, 4, 6, 8, 10};
    enc = '{3'b000, 3'b110, 3'b001, 3'b111,
            3'b100, 3'b101, 3'b010, 3'b011};
    m = (acc < 0) ? -longint'(acc) : longint'(acc);
    m = m / (longint'(1) << sh);
    best = 0;
    for (int i = 1; i < 8; i++) begin
      d_i = m - levels[i];
      d_b = m - levels[best];
      if (d_i < 0) d_i = -d_i;
      if (d_b < 0) d_b = -d_b;
      if (d_i < d_b) best = i;
    end
    sat = (m > 10);
    code = {(acc < 0) && (best != 0), enc[best]};
    if (relu && acc < 0) begin
      code = 4'b0000;
      sat = 1'b0;
    end
  endfunction

  task automatic tick(output bit acc_ok, output bit hs,
                      output logic [3:0] code, output bit have,
                      output logic [3:0] exp);
    logic [3:0] c;
    bit s;
    bit s_front;
    @(negedge clk);
    acc_ok = in_valid && in_ready && !reset;
    hs = out_valid && out_ready && !reset;
    code = out_code;
    have = 1'b0;
    exp = 4'b0000;
    if (hs) begin
      have = q_code.size() > 0;
      if (have) begin
        exp = q_code.pop_front();
        s_front = q_sat.pop_front();
        if (s_front && exp_cnt < 15) exp_cnt++;
      end
    end
    if (acc_ok) begin
      ref_model(int'($signed(in_acc)), int'(in_shift), in_relu, c, s);
      q_code.push_back(c);
      q_sat.push_back(s);
    end
    if (reset) begin
      q_code.delete();
      q_sat.delete();
      exp_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit a, h, hv;
    logic [3:0] c, e;
    reset = 1'b1;
    in_valid = 1'b0;
    tick(a, h, c, hv, e);
    tick(a, h, c, hv, e);
    reset = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    vectors++;
    if (out_code !== 4'b0000) begin
      errors++;
      $display("FAIL reset_out_code got %b want 0000", out_code);
    end
    vectors++;
    if (sat_count !== '0) begin
      errors++;
      $display("FAIL reset_sat_count got %0d want 0", sat_count);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_sweep();
    int vals[12];
    bit a, h, hv;
    logic [3:0] c, e;
    vals = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, -7};
    out_ready = 1'b1;
    in_shift = '0;
    in_relu = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_valid = (i < 12);
      in_acc = (i < 12) ? AW'(vals[i]) : '0;
      tick(a, h, c, hv, e);
      if (h) begin
        vectors++;
        if (!hv || c !== e) begin
          errors++;
          $display("FAIL sweep_code beat %0d got %b want %b", i, c, e);
        end
      end
      if (i == 0) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sweep_latency_early got %b want 0", out_valid);
        end
      end
      if (i == 1) begin
        vectors++;
        if (out_valid !== 1'b1 || out_code !== 4'b0000) begin
          errors++;
          $display("FAIL sweep_latency got %b/%b want 1/0000",
                   out_valid, out_code);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (q_code.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_drain got %0d left want 0", q_code.size());
    end
  endtask

  task automatic test_shift_sat();
    int accs[5];
    int shs[5];
    bit a, h, hv;
    logic [3:0] c, e;
    accs = '{40, 1000, -32768, -32768, 32767};
    shs = '{2, 0, 15, 16, 31};
    out_ready = 1'b1;
    in_relu = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 5);
      in_acc = (i < 5) ? AW'(accs[i]) : '0;
      in_shift = (i < 5) ? SW'(shs[i]) : '0;
      tick(a, h, c, hv, e);
      if (h) begin
        vectors++;
        if (!hv || c !== e) begin
          errors++;
          $display("FAIL shift_code got %b want %b", c, e);
        end
      end
      vectors++;
      if (sat_count !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL shift_sat_count got %0d want %0d", sat_count, exp_cnt);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_relu();
    int accs[3];
    bit a, h, hv;
    logic [3:0] c, e;
    accs = '{-5, -1000, 5};
    out_ready = 1'b1;
    in_shift = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      in_relu = 1'b1;
      in_acc = (i < 3) ? AW'(accs[i]) : '0;
      tick(a, h, c, hv, e);
      if (h) begin
        vectors++;
        if (!hv || c !== e) begin
          errors++;
          $display("FAIL relu_code got %b want %b", c, e);
        end
      end
      vectors++;
      if (sat_count !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL relu_sat_count got %0d want %0d", sat_count, exp_cnt);
      end
    end
    in_valid = 1'b0;
    in_relu = 1'b0;
  endtask

  task automatic test_backpressure();
    int vals[3];
    int idx;
    int n_hs;
    bit a, h, hv;
    logic [3:0] c, e;
    vals = '{1, 2, 3};
    idx = 0;
    n_hs = 0;
    in_shift = '0;
    in_relu = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      out_ready = (cyc >= 6);
      in_valid = (idx < 3);
      in_acc = (idx < 3) ? AW'(vals[idx]) : '0;
      tick(a, h, c, hv, e);
      if (a) idx++;
      if (h) begin
        n_hs++;
        vectors++;
        if (!hv || c !== e) begin
          errors++;
          $display("FAIL bp_order got %b want %b", c, e);
        end
      end
      if (cyc >= 1 && cyc <= 5) begin
        vectors++;
        if (out_valid !== 1'b1 || out_code !== 4'b0110 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold got v%b c%b r%b want v1 c0110 r0",
                   out_valid, out_code, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (n_hs != 3 || q_code.size() != 0) begin
      errors++;
      $display("FAIL bp_count got %0d delivered want 3", n_hs);
    end
  endtask

  task automatic test_reset_mid();
    bit a, h, hv;
    logic [3:0] c, e;
    out_ready = 1'b1;
    in_shift = '0;
    in_relu = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_acc = AW'(2000);
      tick(a, h, c, hv, e);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    tick(a, h, c, hv, e);
    reset = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || sat_count !== '0) begin
      errors++;
      $display("FAIL midreset got v%b n%0d want v0 n0", out_valid, sat_count);
    end
    for (int i = 0; i < 4; i++) begin
      tick(a, h, c, hv, e);
      vectors++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_random();
    bit a, h, hv;
    logic [3:0] c, e;
    out_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || a) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1)
          in_acc = AW'($urandom);
        else
          in_acc = AW'($urandom_range(0, 30) - 15);
        in_shift = ($urandom_range(0, 1) == 1) ? SW'($urandom) : SW'($urandom_range(0, 3));
        in_relu = ($urandom_range(0, 3) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(a, h, c, hv, e);
      if (h) begin
        vectors++;
        if (!hv || c !== e) begin
          errors++;
          $display("FAIL rand_code got %b want %b", c, e);
        end
      end
      vectors++;
      if (sat_count !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL rand_sat_count got %0d want %0d", sat_count, exp_cnt);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(a, h, c, hv, e);
  endtask

  task automatic test_cnt_sat();
    bit a, h, hv;
    logic [3:0] c, e;
    reset = 1'b1;
    tick(a, h, c, hv, e);
    reset = 1'b0;
    out_ready = 1'b1;
    in_shift = '0;
    in_relu = 1'b0;
    for (int i = 0; i < 24; i++) begin
      in_valid = (i < 20);
      in_acc = 16'h7FFF;
      tick(a, h, c, hv, e);
    end
    in_valid = 1'b0;
    vectors++;
    if (sat_count !== 4'd15) begin
      errors++;
      $display("FAIL cnt_sat got %0d want 15", sat_count);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_shift_sat();
    test_relu();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_cnt_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
